// File: rtl/pio_chaser_pkg.sv
// Shared types and constants for the PIO pattern-chaser bus master.
package pio_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_INC  = 2'd0,
        MODE_ROT  = 2'd1,
        MODE_PONG = 2'd2,
        MODE_HOLD = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CHECK,
        ST_WAIT_TICK
    } state_t;

    localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/pio_tick_gen.sv
// Pattern-step prescaler: counts 0..PRESCALE-1 and flags the last count as a tick.
module pio_tick_gen #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == LAST_CNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LAST_CNT);

endmodule

// File: rtl/pio_chaser_master.sv
// Avalon-MM master that writes an LED pattern to the PIO data register and reads it back.
// state        | meaning
// ST_IDLE      | stopped, no requests, busy=0
// ST_WRITE     | avm_write held until waitrequest drops
// ST_READ      | avm_read held until waitrequest drops; readdata compared on that edge
// ST_CHECK     | mismatch pulse visible, err_count updated on exit
// ST_WAIT_TICK | waiting for a (possibly pending) prescaler tick to step the pattern
module pio_chaser_master
    import pio_chaser_pkg::*;
#(
    parameter int PRESCALE = 50000,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic [1:0]        avm_address,
    output logic              avm_write,
    output logic              avm_read,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] pattern,
    output logic              mismatch,
    output logic [7:0]        err_count,
    output logic              busy
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_pattern;
    logic [DATA_W-1:0] w_pat_nxt;
    logic              r_dir_left;
    logic              w_dir_nxt;
    logic              r_pending;
    logic              r_write;
    logic              r_read;
    logic              r_busy;
    logic              r_mismatch;
    logic [7:0]        r_err;
    logic              w_tick;
    logic              w_rd_done;
    logic              w_consume;
    logic              w_unused_rdata;

    pio_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (!enable),
        .o_tick  (w_tick)
    );

    assign w_rd_done      = (r_state == ST_READ) && !avm_waitrequest;
    assign w_consume      = (r_state == ST_WAIT_TICK) && enable && (w_tick || r_pending);
    assign w_unused_rdata = ^avm_readdata[31:DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (enable) w_state_nxt = ST_WRITE;
            ST_WRITE:     if (!avm_waitrequest) w_state_nxt = ST_READ;
            ST_READ:      if (!avm_waitrequest) w_state_nxt = ST_CHECK;
            ST_CHECK:     w_state_nxt = enable ? ST_WAIT_TICK : ST_IDLE;
            ST_WAIT_TICK: begin
                if (!enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick || r_pending) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_pat_nxt = r_pattern;
        w_dir_nxt = r_dir_left;
        case (mode_t'(mode))
            MODE_INC: w_pat_nxt = r_pattern + DATA_W'(1);
            MODE_ROT: w_pat_nxt = {r_pattern[DATA_W-2:0], r_pattern[DATA_W-1]};
            MODE_PONG: begin
                // Endpoints force the direction so a stale dir can never walk off the end.
                if (!$onehot(r_pattern)) begin
                    w_pat_nxt = DATA_W'(1);
                    w_dir_nxt = 1'b1;
                end else if (r_pattern[DATA_W-1]) begin
                    w_pat_nxt = r_pattern >> 1;
                    w_dir_nxt = 1'b0;
                end else if (r_pattern[0]) begin
                    w_pat_nxt = r_pattern << 1;
                    w_dir_nxt = 1'b1;
                end else begin
                    w_pat_nxt = r_dir_left ? (r_pattern << 1) : (r_pattern >> 1);
                end
            end
            default: w_pat_nxt = r_pattern;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write    <= 1'b0;
            r_read     <= 1'b0;
            r_busy     <= 1'b0;
            r_mismatch <= 1'b0;
            r_err      <= 8'd0;
            r_pattern  <= DATA_W'(1);
            r_dir_left <= 1'b1;
            r_pending  <= 1'b0;
        end else begin
            r_write    <= (w_state_nxt == ST_WRITE);
            r_read     <= (w_state_nxt == ST_READ);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_mismatch <= w_rd_done && (avm_readdata[DATA_W-1:0] != r_pattern);
            if ((r_state == ST_CHECK) && r_mismatch && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
            if (w_consume) begin
                r_pattern  <= w_pat_nxt;
                r_dir_left <= w_dir_nxt;
            end
            if (!enable || w_consume) begin
                r_pending <= 1'b0;
            end else if (w_tick && (r_state != ST_WAIT_TICK)) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign avm_address   = PIO_DATA_ADDR;
    assign avm_write     = r_write;
    assign avm_read      = r_read;
    assign avm_writedata = {{(32-DATA_W){1'b0}}, r_pattern};
    assign pattern       = r_pattern;
    assign mismatch      = r_mismatch;
    assign err_count     = r_err;
    assign busy          = r_busy;

endmodule
